// File: rtl/fp64_pkg.sv
// ============================================================================
// fp64_pkg : binary64 field layout and exponent constants shared by the
//            exponent and mantissa paths.          rev 1.0
// ============================================================================
`default_nettype none

package fp64_pkg;

  localparam int BIAS     = 1023;
  localparam int EXP_W    = 11;
  localparam int EXP_MAX  = 2047;
  localparam int SIGN_BIT = 63;
  localparam int EXP_HI   = 62;
  localparam int EXP_LO   = 52;
  localparam int MAN_HI   = 51;
  localparam int MAN_LO   = 0;

  // Operands captured by stage 1
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    logic             za;
    logic             zb;
    logic             sa;
    logic             sb;
  } s1_t;

  // Result held by stage 2
  typedef struct packed {
    logic           sign;
    logic [EXP_W:0] expo;
    logic           nz;
    logic           ovf;
    logic           unf;
    logic           spec;
  } res_t;

  // Subnormals are flushed, so a zero exponent field means zero
  function automatic logic is_zero(input logic [EXP_W-1:0] e);
    return (e == '0);
  endfunction

  function automatic logic is_special(input logic [EXP_W-1:0] e);
    return (e == '1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp64_exp_stage_if.sv
// ============================================================================
// fp64_exp_stage_if : operand/result handshake bundle of the exponent stage.
//                     rev 1.0
// ============================================================================
`default_nettype none

interface fp64_exp_stage_if;
  import fp64_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [63:0]      a;
  logic [63:0]      b;
  logic             out_valid;
  logic             out_ready;
  logic             sign_out;
  logic [EXP_W:0]   exp_out;
  logic             nz_out;
  logic             ovf_out;
  logic             unf_out;
  logic             spec_out;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sign_out, exp_out, nz_out, ovf_out, unf_out, spec_out
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sign_out, exp_out, nz_out, ovf_out, unf_out, spec_out
  );

endinterface

`default_nettype wire

// File: rtl/exp_bias_add.sv
// ============================================================================
// exp_bias_add : ea + eb - BIAS as a 13-bit signed value with range compares.
//                rev 1.0
// ============================================================================
`default_nettype none

module exp_bias_add
  import fp64_pkg::*;
(
  input  wire logic [EXP_W-1:0] ea_i,
  input  wire logic [EXP_W-1:0] eb_i,
  output logic      [EXP_W:0]   e_o,
  output logic                  ge_max_o,
  output logic                  le_zero_o
);

  localparam logic signed [EXP_W+1:0] E_MAX  = (EXP_W+2)'(EXP_MAX);
  localparam logic signed [EXP_W+1:0] E_BIAS = (EXP_W+2)'(BIAS);

  logic signed [EXP_W+1:0] e_full;

  // Sum spans -1023..3071, which fits 13 bits signed
  assign e_full    = $signed({2'b00, ea_i}) + $signed({2'b00, eb_i}) - E_BIAS;
  assign e_o       = e_full[EXP_W:0];
  assign ge_max_o  = (e_full >= E_MAX);
  assign le_zero_o = (e_full <= 0);

endmodule

`default_nettype wire

// File: rtl/fp64_exp_stage.sv
// ============================================================================
// fp64_exp_stage : two-stage valid/ready exponent path of the binary64
//                  multiplier (sign, biased exponent, class flags). rev 1.0
// ============================================================================
`default_nettype none

module fp64_exp_stage
  import fp64_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst_n,
  fp64_exp_stage_if.slave  bus
);

  logic           s1_valid_q;
  s1_t            s1_q;
  s1_t            s1_d;
  logic           out_valid_q;
  res_t           res_q;
  res_t           res_d;
  logic           s2_adv;
  logic           in_rdy;
  logic [EXP_W:0] e_sum;
  logic           ge_max;
  logic           le_zero;
  logic           nz;
  logic           spec;
  logic           unused_man;

  // Mantissa bits belong to the mantissa stage
  assign unused_man = ^{bus.a[MAN_HI:MAN_LO], bus.b[MAN_HI:MAN_LO]};

  assign s2_adv = !out_valid_q || bus.out_ready;
  assign in_rdy = !s1_valid_q || s2_adv;

  always_comb begin
    s1_d      = '0;
    s1_d.sign = bus.a[SIGN_BIT] ^ bus.b[SIGN_BIT];
    s1_d.ea   = bus.a[EXP_HI:EXP_LO];
    s1_d.eb   = bus.b[EXP_HI:EXP_LO];
    s1_d.za   = is_zero(bus.a[EXP_HI:EXP_LO]);
    s1_d.zb   = is_zero(bus.b[EXP_HI:EXP_LO]);
    s1_d.sa   = is_special(bus.a[EXP_HI:EXP_LO]);
    s1_d.sb   = is_special(bus.b[EXP_HI:EXP_LO]);
  end

  exp_bias_add u_bias_add (
    .ea_i      (s1_q.ea),
    .eb_i      (s1_q.eb),
    .e_o       (e_sum),
    .ge_max_o  (ge_max),
    .le_zero_o (le_zero)
  );

  assign nz   = !(s1_q.za || s1_q.zb);
  assign spec = s1_q.sa || s1_q.sb;

  // Zero dominates special: 0 x Inf leaves exponent 0 and lets downstream pick NaN
  always_comb begin
    res_d      = '0;
    res_d.sign = s1_q.sign;
    res_d.nz   = nz;
    res_d.spec = spec;
    res_d.ovf  = nz && !spec && ge_max;
    res_d.unf  = nz && !spec && le_zero;
    if (res_d.unf || !nz)
      res_d.expo = '0;
    else if (spec)
      res_d.expo = '1;
    else
      res_d.expo = e_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      if (in_rdy) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid)
          s1_q <= s1_d;
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q)
          res_q <= res_d;
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.sign_out  = res_q.sign;
  assign bus.exp_out   = res_q.expo;
  assign bus.nz_out    = res_q.nz;
  assign bus.ovf_out   = res_q.ovf;
  assign bus.unf_out   = res_q.unf;
  assign bus.spec_out  = res_q.spec;

endmodule

`default_nettype wire
